// File: rtl/scan_mux.sv
// ---------------------------------------------------------------------------
// scan_mux
//
// Channel multiplexer for multiplexed displays. In manual mode the word and
// one-hot strobe of the channel chosen by i_ctrl appear one cycle later. In
// auto mode the block walks the enabled channels in turn: each is shown for
// max(i_div,1) cycles, then the outputs are blanked for BLANK_CYC cycles,
// then the next enabled channel (upward, wrapping) is selected.
//
// Ports
//   i_clk    clock, all state changes on rising edge
//   i_rst    asynchronous active-high reset
//   i_data   NUM_CH packed words, channel k at [k*DATA_W +: DATA_W]
//   i_mode   0 = manual select, 1 = auto scan
//   i_ctrl   manual channel select (also the auto start channel)
//   i_div    auto dwell length in cycles (0 behaves as 1)
//   i_ch_en  channel enable mask used by the auto scan
//   o_data   registered selected word (0 while blanked)
//   o_sel    registered one-hot strobe of the live channel (0 while blanked)
//   o_ch     registered index of the active channel (held while blanked)
//   o_valid  high when o_data/o_sel carry a live channel
// ---------------------------------------------------------------------------
module scan_mux #(
  parameter int DATA_W    = 9,
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 2,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic                     i_mode,
  input  logic [CH_W-1:0]          i_ctrl,
  input  logic [DIV_W-1:0]         i_div,
  input  logic [NUM_CH-1:0]        i_ch_en,
  output logic [DATA_W-1:0]        o_data,
  output logic [NUM_CH-1:0]        o_sel,
  output logic [CH_W-1:0]          o_ch,
  output logic                     o_valid
);

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  dwell_reg, dwell_next;
  logic [7:0]        blank_reg, blank_next;
  logic [CH_W-1:0]   ptr_reg, ptr_next;
  // Mode seen on the previous edge; a 0 here while i_mode is 1 marks the
  // first auto cycle, which restarts the scan from i_ctrl.
  logic              auto_reg;

  logic [DATA_W-1:0] data_next;
  logic [NUM_CH-1:0] sel_next;
  logic [CH_W-1:0]   ch_next;
  logic              valid_next;

  // Unpacked view of the channel words
  logic [DATA_W-1:0] words [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_words
      assign words[gi] = i_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic            ctrl_ok;
  logic [CH_W-1:0] ctrl_idx;

  assign ctrl_ok  = (int'(i_ctrl) < NUM_CH);
  assign ctrl_idx = ctrl_ok ? i_ctrl : '0;

  // Effective scan context for this cycle: on the first auto cycle after
  // manual mode the scan starts fresh at the manual channel with a full
  // dwell, so that cycle already counts as the first shown cycle.
  state_t           cur_state;
  logic [DIV_W-1:0] cur_dwell;
  logic [7:0]       cur_blank;
  logic [CH_W-1:0]  cur_ptr;

  always_comb begin
    if (auto_reg) begin
      cur_state = state_reg;
      cur_dwell = dwell_reg;
      cur_blank = blank_reg;
      cur_ptr   = ptr_reg;
    end else begin
      cur_state = SHOW;
      cur_dwell = '0;
      cur_blank = '0;
      cur_ptr   = ctrl_idx;
    end
  end

  // Next enabled channel after cur_ptr, searching upward with wrap. The last
  // candidate is cur_ptr itself, so a lone enabled channel is reselected.
  logic [CH_W-1:0] adv_ptr;
  logic            any_en;

  always_comb begin
    int idx;
    adv_ptr = cur_ptr;
    any_en  = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(cur_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_en && i_ch_en[idx]) begin
        any_en  = 1'b1;
        adv_ptr = CH_W'(idx);
      end
    end
  end

  // Dwell end compares against the live i_div, so shortening it mid-dwell
  // ends the dwell at once when the count is already past the new limit.
  logic [DIV_W-1:0] div_lim;
  logic [DIV_W:0]   dwell_inc;
  logic             dwell_done;
  logic             blank_done;

  assign div_lim    = (i_div == '0) ? DIV_W'(1) : i_div;
  assign dwell_inc  = {1'b0, cur_dwell} + {{DIV_W{1'b0}}, 1'b1};
  assign dwell_done = (dwell_inc >= {1'b0, div_lim});
  // Saturates at the terminal count, where an empty mask parks the FSM
  assign blank_done = ((int'(cur_blank) + 1) >= BLANK_CYC);

  // ---------------- state register ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= SHOW;
      dwell_reg <= '0;
      blank_reg <= '0;
      ptr_reg   <= '0;
      // Reset leaves the scanner at channel 0; no restart from i_ctrl
      auto_reg  <= 1'b1;
      o_data    <= '0;
      o_sel     <= '0;
      o_ch      <= '0;
      o_valid   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dwell_reg <= dwell_next;
      blank_reg <= blank_next;
      ptr_reg   <= ptr_next;
      auto_reg  <= i_mode;
      o_data    <= data_next;
      o_sel     <= sel_next;
      o_ch      <= ch_next;
      o_valid   <= valid_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = cur_state;
    dwell_next = cur_dwell;
    blank_next = cur_blank;
    ptr_next   = cur_ptr;
    if (!i_mode) begin
      state_next = SHOW;
      dwell_next = '0;
      blank_next = '0;
      ptr_next   = ptr_reg;
    end else begin
      case (cur_state)
        SHOW: begin
          if (dwell_done) begin
            dwell_next = '0;
            blank_next = '0;
            if (BLANK_CYC == 0 && any_en) begin
              ptr_next   = adv_ptr;
              state_next = SHOW;
            end else begin
              state_next = BLANK;
            end
          end else begin
            dwell_next = dwell_inc[DIV_W-1:0];
          end
        end
        BLANK: begin
          if (blank_done) begin
            // Empty mask: stay parked and look at the mask again next cycle
            if (any_en) begin
              ptr_next   = adv_ptr;
              state_next = SHOW;
              blank_next = '0;
            end
          end else begin
            blank_next = cur_blank + 8'd1;
          end
        end
        default: state_next = SHOW;
      endcase
    end
  end

  // ---------------- output logic ----------------
  always_comb begin
    data_next  = '0;
    sel_next   = '0;
    ch_next    = o_ch;
    valid_next = 1'b0;
    if (!i_mode) begin
      ch_next = i_ctrl;
      if (ctrl_ok) begin
        data_next  = words[i_ctrl];
        sel_next   = onehot(i_ctrl);
        valid_next = 1'b1;
      end
    end else if (cur_state == SHOW) begin
      data_next  = words[cur_ptr];
      sel_next   = onehot(cur_ptr);
      ch_next    = cur_ptr;
      valid_next = 1'b1;
    end
  end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter DATA_W, default 9, width of each channel word.
REQ-002 Parameter NUM_CH, default 4, channel count, legal range 2..16.
REQ-003 Parameter DIV_W, default 16, width of the dwell-period input.
REQ-004 Parameter BLANK_CYC, default 2, blanking cycles between channels in auto mode, legal range 0..255.
REQ-005 Derived CH_W = clog2(NUM_CH).
REQ-006 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-007 i_rst  input  1  reset, asynchronous, active-high.
REQ-008 i_data  input  NUM_CH*DATA_W  packed channel words; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 i_mode  input  1  0 = manual select, 1 = auto scan.
REQ-010 i_ctrl  input  CH_W  manual channel select.
REQ-011 i_div  input  DIV_W  auto-mode dwell length in cycles; 0 is treated as 1.
REQ-012 i_ch_en  input  NUM_CH  channel enable mask; disabled channels are skipped in auto mode.
REQ-013 o_data  output  DATA_W  registered selected word.
REQ-014 o_sel  output  NUM_CH  registered one-hot digit strobe for the active channel; all zero while blanked.
REQ-015 o_ch  output  CH_W  registered index of the active channel.
REQ-016 o_valid  output  1  high when o_data/o_sel carry a live channel.

Function
REQ-017 Internal FSM states: SHOW and BLANK; dwell counter DIV_W bits; blank counter 8 bits; channel pointer CH_W bits.
REQ-018 Manual mode: each cycle, o_ch <= i_ctrl, o_data <= word[i_ctrl], o_sel <= onehot(i_ctrl), o_valid <= 1; latency 1 cycle; i_ch_en ignored; i_ctrl >= NUM_CH gives o_data 0, o_sel 0, o_valid 0.
REQ-019 Auto SHOW: each cycle o_data <= word[ptr] (live data tracking), o_sel <= onehot(ptr), o_ch <= ptr, o_valid <= 1; dwell counter increments.
REQ-020 Auto SHOW exit: when dwell counter reaches max(i_div,1)-1, counter clears and FSM enters BLANK (or, if BLANK_CYC = 0, advances directly per REQ-022).
REQ-021 Auto BLANK: o_data <= 0, o_sel <= 0, o_valid <= 0, o_ch holds; after exactly BLANK_CYC cycles, advance per REQ-022.
REQ-022 Advance: ptr <= next enabled channel after ptr, searching upward with wrap from NUM_CH-1 to 0; if ptr is the only enabled channel it is reselected; FSM enters SHOW.
REQ-023 Exactly one channel is shown per dwell; with i_div = D, consecutive enabled channels start SHOW every D + BLANK_CYC cycles.
REQ-024 If i_ch_en = 0 in auto mode, FSM stays in BLANK with outputs blanked and re-evaluates the mask every cycle; first cycle a bit is set, advance per REQ-022.
REQ-025 If the current channel is disabled mid-SHOW, SHOW completes its dwell unchanged; the mask only affects advance.
REQ-026 i_div changed mid-dwell takes effect immediately; if counter already >= new limit-1, dwell ends on that cycle.
REQ-027 Manual->auto transition: ptr <= i_ctrl (0 if out of range), dwell counter cleared, FSM SHOW.
REQ-028 Auto->manual transition: manual behaviour from the next edge; FSM forced to SHOW, counters cleared.
REQ-029 o_sel is always one-hot or zero; never more than one bit set.

Reset
REQ-030 While i_rst is high, asynchronously: o_data = 0, o_sel = 0, o_ch = 0, o_valid = 0, ptr = 0, counters = 0, FSM = SHOW.
REQ-031 Reset asserted mid-dwell or mid-blank discards all progress; after release, first update is per mode on the first rising edge.

Verification
REQ-032 Reset: assert i_rst between edges -> all outputs 0 immediately, no clock needed.
REQ-033 Manual: i_mode=0, words 0x0A1,0x0B2,0x0C3,0x0D4, i_ctrl 0..3 stepping each cycle -> o_data follows one cycle later, o_sel 0001,0010,0100,1000.
REQ-034 Auto scan: i_mode=1, i_div=4, BLANK_CYC=2, mask 1111 -> per channel 4 cycles o_valid=1 then 2 cycles o_sel=0; order 0,1,2,3,0; period 6 cycles.
REQ-035 Mask skip: mask 1010, i_div=3 -> only channels 1 and 3 shown, alternating, never 0 or 2.
REQ-036 Empty mask then recovery: mask 0000 for 20 cycles -> o_valid=0 throughout; set 0100 -> channel 2 shown on next advance.
REQ-037 Edge cases: i_div=0 behaves as 1; mode switch manual->auto with i_ctrl=2 -> scan starts at channel 2 with full dwell.
